// File: rtl/freq_meter.sv
// freq_meter: gated-window frequency counter, one count of sig_in rising edges per GATE_CYCLES window.
// Defining FREQ_METER_BCD_EN adds a sequential double-dabble converter that drives bcd/bcd_valid.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 27
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] freq,
    output logic             valid,
    output logic             ovf,
    output logic             busy,
    output logic [31:0]      bcd,
    output logic             bcd_valid
);
    localparam int unsigned       GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {IDLE, GATE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_sync1, r_sync2, r_sync3, r_edge;
    logic [GATE_W-1:0] r_gate_cnt, w_gate_cnt_nxt;
    logic [CNT_W-1:0]  r_edge_cnt, w_edge_cnt_nxt;
    logic              r_ovf_pend, w_ovf_pend_nxt;
    logic              w_win_end;
    logic [CNT_W:0]    w_sum;
    logic              w_sum_sat;
    logic [CNT_W-1:0]  w_res;
    logic              w_res_ovf;
    logic [CNT_W-1:0]  r_res;
    logic              r_res_ovf, r_res_rdy;

    // Window FSM: the closing cycle's edge is folded into the published result.
    always_comb begin
        w_state_nxt    = r_state;
        w_gate_cnt_nxt = r_gate_cnt;
        w_edge_cnt_nxt = r_edge_cnt;
        w_ovf_pend_nxt = r_ovf_pend;
        w_win_end      = 1'b0;
        w_sum          = {1'b0, r_edge_cnt} + (CNT_W+1)'(r_edge);
        w_sum_sat      = (w_sum >= {1'b0, CNT_MAX});
        w_res          = w_sum_sat ? CNT_MAX : w_sum[CNT_W-1:0];
        w_res_ovf      = r_ovf_pend | w_sum_sat;
        case (r_state)
            IDLE: begin
                w_gate_cnt_nxt = '0;
                w_edge_cnt_nxt = '0;
                w_ovf_pend_nxt = 1'b0;
                if (en) w_state_nxt = GATE;
            end
            GATE: begin
                if (r_gate_cnt == GATE_LAST) begin
                    w_win_end      = 1'b1;
                    w_gate_cnt_nxt = '0;
                    w_edge_cnt_nxt = '0;
                    w_ovf_pend_nxt = 1'b0;
                    if (!en) w_state_nxt = IDLE;
                end else if (!en) begin
                    w_state_nxt    = IDLE;
                    w_gate_cnt_nxt = '0;
                    w_edge_cnt_nxt = '0;
                    w_ovf_pend_nxt = 1'b0;
                end else begin
                    w_gate_cnt_nxt = r_gate_cnt + GATE_W'(1);
                    w_edge_cnt_nxt = w_res;
                    w_ovf_pend_nxt = w_res_ovf;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result is staged one cycle so freq, ovf and valid change on the same edge.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_edge     <= 1'b0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_pend <= 1'b0;
            r_res      <= '0;
            r_res_ovf  <= 1'b0;
            r_res_rdy  <= 1'b0;
            freq       <= '0;
            ovf        <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_sync1    <= sig_in;
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2;
            r_edge     <= r_sync2 & ~r_sync3;
            r_state    <= w_state_nxt;
            r_gate_cnt <= w_gate_cnt_nxt;
            r_edge_cnt <= w_edge_cnt_nxt;
            r_ovf_pend <= w_ovf_pend_nxt;
            r_res_rdy  <= w_win_end;
            if (w_win_end) begin
                r_res     <= w_res;
                r_res_ovf <= w_res_ovf;
            end
            valid <= r_res_rdy;
            if (r_res_rdy) begin
                freq <= r_res;
                ovf  <= r_res_ovf;
            end
            busy <= (r_state == GATE);
        end
    end

`ifdef FREQ_METER_BCD_EN
    localparam int unsigned BCD_MAX = 99999999;
    localparam int unsigned CMP_W   = (CNT_W > 27) ? CNT_W : 27;
    localparam int unsigned DD_W    = $clog2(CNT_W + 1);

    typedef enum logic {CONV_IDLE, CONV_SHIFT} conv_t;

    conv_t            r_conv, w_conv_nxt;
    logic [CNT_W-1:0] r_dd_bin, w_dd_bin_nxt, w_dd_load;
    logic [31:0]      r_dd_bcd, w_dd_bcd_nxt, w_dd_adj;
    logic [DD_W-1:0]  r_dd_cnt, w_dd_cnt_nxt;
    logic [31:0]      w_bcd_nxt;
    logic             w_bcd_valid_nxt;

    // Double dabble: add-3 on digits >= 5, then shift one binary bit in; a new result restarts it.
    always_comb begin
        w_conv_nxt      = r_conv;
        w_dd_bin_nxt    = r_dd_bin;
        w_dd_bcd_nxt    = r_dd_bcd;
        w_dd_cnt_nxt    = r_dd_cnt;
        w_bcd_nxt       = bcd;
        w_bcd_valid_nxt = 1'b0;
        w_dd_load       = (CMP_W'(r_res) > CMP_W'(BCD_MAX)) ? CNT_W'(BCD_MAX) : r_res;
        w_dd_adj        = r_dd_bcd;
        for (int i = 0; i < 8; i++) begin
            if (r_dd_bcd[4*i +: 4] >= 4'd5) w_dd_adj[4*i +: 4] = r_dd_bcd[4*i +: 4] + 4'd3;
        end
        if (r_res_rdy) begin
            w_conv_nxt   = CONV_SHIFT;
            w_dd_bin_nxt = w_dd_load;
            w_dd_bcd_nxt = '0;
            w_dd_cnt_nxt = '0;
        end else begin
            case (r_conv)
                CONV_IDLE: ;
                CONV_SHIFT: begin
                    if (r_dd_cnt == DD_W'(CNT_W)) begin
                        w_bcd_nxt       = r_dd_bcd;
                        w_bcd_valid_nxt = 1'b1;
                        w_conv_nxt      = CONV_IDLE;
                    end else begin
                        w_dd_bcd_nxt = {w_dd_adj[30:0], r_dd_bin[CNT_W-1]};
                        w_dd_bin_nxt = r_dd_bin << 1;
                        w_dd_cnt_nxt = r_dd_cnt + DD_W'(1);
                    end
                end
                default: w_conv_nxt = CONV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            r_conv    <= CONV_IDLE;
            r_dd_bin  <= '0;
            r_dd_bcd  <= '0;
            r_dd_cnt  <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            r_conv    <= w_conv_nxt;
            r_dd_bin  <= w_dd_bin_nxt;
            r_dd_bcd  <= w_dd_bcd_nxt;
            r_dd_cnt  <= w_dd_cnt_nxt;
            bcd       <= w_bcd_nxt;
            bcd_valid <= w_bcd_valid_nxt;
        end
    end
`else
    assign bcd       = '0;
    assign bcd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: drives two freq_meter instances (27-bit and 8-bit counters) from one stimulus
// and checks them every cycle against a window-level model of edge timestamps.
module tb_freq_meter;
    localparam int unsigned G  = 1000;
    localparam int unsigned W  = 27;
    localparam int unsigned W8 = 8;
    localparam longint MAX_A = (64'd1 << W) - 1;
    localparam longint MAX_B = (64'd1 << W8) - 1;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst, sig_in, en;
    logic [W-1:0]  freq_a;
    logic [W8-1:0] freq_b;
    logic valid_a, ovf_a, busy_a, bcdv_a;
    logic valid_b, ovf_b, busy_b, bcdv_b;
    logic [31:0] bcd_a, bcd_b;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(W)) u_dut_a (
        .clk_50MHz(clk), .rst(rst), .sig_in(sig_in), .en(en),
        .freq(freq_a), .valid(valid_a), .ovf(ovf_a), .busy(busy_a),
        .bcd(bcd_a), .bcd_valid(bcdv_a)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(W8)) u_dut_b (
        .clk_50MHz(clk), .rst(rst), .sig_in(sig_in), .en(en),
        .freq(freq_b), .valid(valid_b), .ovf(ovf_b), .busy(busy_b),
        .bcd(bcd_b), .bcd_valid(bcdv_b)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] to_bcd(input longint v);
        logic [31:0] r;
        longint x;
        r = '0;
        x = (v > 99999999) ? 99999999 : v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // sig_in generator: square wave of 'period' cycles, changed only on negedges
    int period = 2;
    initial begin
        int ph;
        ph = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            sig_in = (period > 0) ? ((ph % period) < (period / 2)) : 1'b0;
            ph++;
        end
    end

    // Window model: timestamp every sampled rise; a rise sampled at edge k is counted at edge k+3,
    // a window opened at edge t counts edges t+1..t+G and publishes at t+G+1.
    bit     m_live = 1'b0, m_prev = 1'b0, m_open = 1'b0;
    int     m_start = 0, m_sched = -1;
    longint m_raw = 0;
    int     rises[$];
    logic   e_valid = 1'b0, e_busy = 1'b0, e_ovf_a = 1'b0, e_ovf_b = 1'b0;
    logic [W-1:0]  e_freq_a = '0;
    logic [W8-1:0] e_freq_b = '0;
    logic [31:0]   e_bcd_a = '0, e_bcd_b = '0, bp_a = '0, bp_b = '0;
    logic   e_bcdv_a = 1'b0, e_bcdv_b = 1'b0;
    int     bs_a = -1, bs_b = -1;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            e_valid  = 1'b0;
            e_bcdv_a = 1'b0;
            e_bcdv_b = 1'b0;
            if (rst) begin
                m_live = 1'b1; m_prev = 1'b0; m_open = 1'b0; m_sched = -1;
                rises.delete();
                e_busy = 1'b0; e_freq_a = '0; e_freq_b = '0; e_ovf_a = 1'b0; e_ovf_b = 1'b0;
                e_bcd_a = '0; e_bcd_b = '0; bs_a = -1; bs_b = -1;
            end else begin
                e_busy = m_open;
                if (sig_in && !m_prev) rises.push_back(cyc);
                m_prev = sig_in;
                if (cyc == bs_a) begin e_bcd_a = bp_a; e_bcdv_a = 1'b1; end
                if (cyc == bs_b) begin e_bcd_b = bp_b; e_bcdv_b = 1'b1; end
                if (cyc == m_sched) begin
                    e_valid  = 1'b1;
                    e_freq_a = (m_raw > MAX_A) ? W'(MAX_A) : W'(m_raw);
                    e_freq_b = (m_raw > MAX_B) ? W8'(MAX_B) : W8'(m_raw);
                    e_ovf_a  = (m_raw >= MAX_A);
                    e_ovf_b  = (m_raw >= MAX_B);
`ifdef FREQ_METER_BCD_EN
                    bs_a = cyc + W + 1;  bp_a = to_bcd(longint'(e_freq_a));
                    bs_b = cyc + W8 + 1; bp_b = to_bcd(longint'(e_freq_b));
`endif
                end
                if (!m_open) begin
                    if (en) begin m_open = 1'b1; m_start = cyc; end
                end else if (cyc == m_start + G) begin
                    m_raw = 0;
                    foreach (rises[i]) if (rises[i] + 3 > m_start && rises[i] + 3 <= m_start + G) m_raw++;
                    while (rises.size() > 0 && rises[0] + 3 <= m_start + G) void'(rises.pop_front());
                    m_sched = cyc + 1;
                    if (en) m_start = cyc; else m_open = 1'b0;
                end else if (!en) begin
                    m_open = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("valid_a", 64'(valid_a), 64'(e_valid));
                chk("valid_b", 64'(valid_b), 64'(e_valid));
                chk("busy_a",  64'(busy_a),  64'(e_busy));
                chk("busy_b",  64'(busy_b),  64'(e_busy));
                chk("freq_a",  64'(freq_a),  64'(e_freq_a));
                chk("freq_b",  64'(freq_b),  64'(e_freq_b));
                chk("ovf_a",   64'(ovf_a),   64'(e_ovf_a));
                chk("ovf_b",   64'(ovf_b),   64'(e_ovf_b));
                chk("bcd_a",   64'(bcd_a),   64'(e_bcd_a));
                chk("bcd_b",   64'(bcd_b),   64'(e_bcd_b));
                chk("bcdv_a",  64'(bcdv_a),  64'(e_bcdv_a));
                chk("bcdv_b",  64'(bcdv_b),  64'(e_bcdv_b));
            end
        end
    end

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid_a === 1'b1) begin
                at = cyc;
                break;
            end
        end
        n_chk++;
        if (at < 0) begin
            n_err++;
            $display("FAIL wait_valid: got timeout expected valid within %0d cycles (cycle %0d)", budget, cyc);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int at, prev, en_cyc, n_v;
        longint sum;
        rst = 1'b1; en = 1'b1; period = 2;
        repeat (3) @(negedge clk);
        chk("rst_freq",  64'(freq_a), 64'd0);
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_busy",  64'(busy_a), 64'd0);
        chk("rst_ovf",   64'(ovf_b), 64'd0);
        chk("rst_bcd",   64'(bcd_a), 64'd0);

        // first window after reset release
        rst = 1'b0; period = 20; en_cyc = cyc + 1;
        wait_valid(G + 50, at);
        chk("first_latency", 64'(at - en_cyc), 64'(G + 1));
        prev = at;

        // steady 20-cycle period: 50 edges per window, back-to-back
        for (int w = 0; w < 3; w++) begin
            wait_valid(G + 50, at);
            chk("steady_spacing", 64'(at - prev), 64'(G));
            chk("steady_freq", 64'(freq_a), 64'd50);
            chk("steady_ovf", 64'(ovf_a), 64'd0);
            prev = at;
        end

        // max rate: 500 per window, 8-bit instance saturates
        period = 2;
        wait_valid(G + 50, at);
        prev = at;
        sum = 0;
        for (int w = 0; w < 10; w++) begin
            wait_valid(G + 50, at);
            chk("max_spacing", 64'(at - prev), 64'(G));
            chk("max_freq_a", 64'(freq_a), 64'd500);
            chk("max_ovf_a", 64'(ovf_a), 64'd0);
            chk("sat_freq_b", 64'(freq_b), 64'd255);
            chk("sat_ovf_b", 64'(ovf_b), 64'd1);
            sum += longint'(freq_a);
            prev = at;
        end
        chk("max_sum10", 64'(sum), 64'd5000);

        // recovery from saturation
        period = 20;
        wait_valid(G + 50, at);
        wait_valid(G + 50, at);
        chk("recover_freq_b", 64'(freq_b), 64'd50);
        chk("recover_ovf_b", 64'(ovf_b), 64'd0);

        // abort at gate_cnt = 400
        repeat (399) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", 64'(busy_a), 64'd0);
        n_v = 0;
        repeat (1200) begin
            @(negedge clk);
            if (valid_a === 1'b1) n_v++;
        end
        chk("abort_no_valid", 64'(n_v), 64'd0);
        chk("abort_hold", 64'(freq_a), 64'd50);
        en = 1'b1; en_cyc = cyc + 1;
        wait_valid(G + 50, at);
        chk("rearm_latency", 64'(at - en_cyc), 64'(G + 1));
        chk("rearm_freq", 64'(freq_a), 64'd50);

        // reset in the middle of a window
        repeat (300) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_freq", 64'(freq_a), 64'd0);
        chk("midrst_busy", 64'(busy_a), 64'd0);
        chk("midrst_freq_b", 64'(freq_b), 64'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
